psram_arbiter: RTL and testbench
================================

# psram_arbiter

Parametrised N-channel front end for the `ddr100_psram` user interface. It sits between several independent masters and the single controller port, and arbitrates `ps_re`/`ps_we` commands round-robin. It tracks outstanding reads in an in-order tag FIFO and steers each returned `ps_rdata`/`ps_rdready` back to the channel that issued the read. The controller sees one well-behaved master, and each channel sees a private copy of the controller handshake.

## Interface
Parameters:
- `NCH`, 2: number of master channels (1..8).
- `AW`, 25: word-address width (`ps_addr[26:2]`).
- `DW`, 32: data width; byte enables are `DW/8`.
- `RDQ_DEPTH`, 4: maximum outstanding reads (power of two, ≥2).

Ports:
- `clk100m`  in  1  controller clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ch_addr`  in  `NCH*AW`  per-channel word address; channel i is at `[i*AW +: AW]`.
- `ch_re`  in  `NCH`  per-channel read request.
- `ch_we`  in  `NCH`  per-channel write request.
- `ch_wdata`  in  `NCH*DW`  per-channel write data.
- `ch_wbe`  in  `NCH*DW/8`  per-channel byte enables.
- `ch_cmdready`  out  `NCH`  command accepted this cycle (one-hot or zero).
- `ch_rdata`  out  `DW`  read data, broadcast to all channels (equals `ps_rdata`).
- `ch_rdready`  out  `NCH`  read data valid for that channel (one-hot or zero).
- `ps_addr`, `ps_re`, `ps_we`, `ps_wdata`, `ps_wbe`, `ps_refresh`  out  controller command port.
- `ps_cmdready`, `ps_rdata`, `ps_rdready`  in  controller responses.
- `rd_outstanding`  out  `$clog2(RDQ_DEPTH+1)`  number of reads in flight.
- `rd_orphan`  out  1  sticky flag, set when `ps_rdready` arrives with no read outstanding.

## Operation
- Channel request: `ch_re[i] | ch_we[i]`. When both are set, the command is a write.
- Eligibility: a write is always eligible. A read is eligible only if the tag FIFO is not full.
- Grant FSM, states IDLE and GRANT(g):
  - IDLE → GRANT(g) on the next edge if any channel is eligible. g is the first eligible channel scanning upward (with wrap) from `rr_ptr`.
  - GRANT(g) holds while `ps_cmdready`=0.
  - On an edge where GRANT(g) and `ps_cmdready`=1, the command is accepted and `rr_ptr` becomes g+1 mod NCH. The next state is GRANT(next eligible from the new `rr_ptr`, excluding g's accepted command), or IDLE if none is eligible.
  - Back-to-back grants therefore have no idle cycle.
- In GRANT(g), the `ps_*` command outputs are a combinational mux of channel g. Writes drive `ps_we`=1 and `ps_re`=0. Reads drive `ps_re`=1 and `ps_we`=0.
- In IDLE, `ps_re`, `ps_we`, `ps_addr`, `ps_wdata` and `ps_wbe` are 0.
- `ps_refresh` = 1 in IDLE, 0 in GRANT.
- `ch_cmdready[g]` = GRANT(g) & `ps_cmdready`. All other bits are 0.
- A channel must hold its request and operands stable until it sees `ch_cmdready`. If a granted channel drops its request before acceptance, the grant is released (→ IDLE) on the next edge. No command is issued and the pointer does not advance.
- Tag FIFO:
  - Push g on read acceptance.
  - Pop on `ps_rdready`=1; `ch_rdready[head]` = 1 in that same cycle (combinational).
  - Simultaneous push and pop are both performed, and the count is unchanged.
  - Full is evaluated before the pop: a read is not eligible when the FIFO is full, even if a pop occurs in the same cycle.
- `ps_rdready` with an empty FIFO: all `ch_rdready` bits stay 0, `rd_orphan` is set (cleared only by `rst`), and the FIFO is unchanged.
- Reset values: FSM=IDLE, `rr_ptr`=0, FIFO empty, `rd_outstanding`=0, `rd_orphan`=0.
  - All `ch_cmdready`, `ch_rdready`, `ps_re`, `ps_we`, `ps_addr`, `ps_wdata` and `ps_wbe` are 0; `ps_refresh`=1.
  - Reset mid-transaction discards the grant and all outstanding tags. Read data arriving afterwards is treated as orphan.

## Timing
- Request-to-grant latency: 1 cycle from IDLE. A request seen at edge N presents `ps_re`/`ps_we` after edge N.
- Acceptance occurs at the first edge where `ps_cmdready`=1 while granted.
- Maximum throughput: one command per cycle when `ps_cmdready` stays high.
- Read return adds 0 cycles: `ch_rdready` and `ch_rdata` mirror `ps_rdready` and `ps_rdata` in the same cycle.
- Returns are strictly in issue order, matching the controller's in-order read return.
- `rd_outstanding` updates at the edge of push or pop.

## Test plan
- Single channel, NCH=2: ch0 writes `0x123457`/`0xA90D20D2`/`4'b1111`, then reads `0x123457`.
  - Required: `ps_we` asserted 1 cycle after the request.
  - Required: `ch_cmdready[0]` is the only ready bit.
  - Required: `ch_rdready[0]` with `ch_rdata`=`0xA90D20D2`; `ch_rdready[1]` never set.
- Contention: ch0 and ch1 both request writes continuously with `ps_cmdready` tied high.
  - Required: grants alternate 0,1,0,1 with no IDLE cycles.
  - Required: `ps_refresh`=0 throughout.
- Read interleave: ch0 reads A, ch1 reads B, ch0 reads C; the controller returns three `ps_rdready` pulses.
  - Required: `ch_rdready` sequence is 0,1,0 with the matching data.
  - Required: `rd_outstanding` goes 1,2,3 and then back to 0.
- FIFO full, RDQ_DEPTH=4: issue 4 reads with no return.
  - Required: a 5th read is not granted and a pending write from the other channel is still granted.
  - Required: after one `ps_rdready`, the 5th read is granted on the following edge.
- Orphan: pulse `ps_rdready` with no reads outstanding.
  - Required: all `ch_rdready`=0 and `rd_orphan`=1, which stays set until `rst`.
- Reset mid-op: assert `rst` while GRANT(1) with 2 reads outstanding.
  - Required: all outputs return to their reset values immediately (asynchronously), `rd_outstanding`=0, and `ps_refresh`=1.

Source files
------------

// File: rtl/psram_arbiter.sv
// Round-robin N-channel front end for the ddr100_psram user port.
// Grants one channel at a time, and an in-order tag FIFO routes read returns back to the issuing channel.
module psram_arbiter #(
  parameter int NCH       = 2,
  parameter int AW        = 25,
  parameter int DW        = 32,
  parameter int RDQ_DEPTH = 4
) (
  input  logic                               clk100m,
  input  logic                               rst,
  input  logic [NCH*AW-1:0]                  ch_addr,
  input  logic [NCH-1:0]                     ch_re,
  input  logic [NCH-1:0]                     ch_we,
  input  logic [NCH*DW-1:0]                  ch_wdata,
  input  logic [NCH*(DW/8)-1:0]              ch_wbe,
  output logic [NCH-1:0]                     ch_cmdready,
  output logic [DW-1:0]                      ch_rdata,
  output logic [NCH-1:0]                     ch_rdready,
  output logic [AW-1:0]                      ps_addr,
  output logic                               ps_re,
  output logic                               ps_we,
  output logic [DW-1:0]                      ps_wdata,
  output logic [DW/8-1:0]                    ps_wbe,
  output logic                               ps_refresh,
  input  logic                               ps_cmdready,
  input  logic [DW-1:0]                      ps_rdata,
  input  logic                               ps_rdready,
  output logic [$clog2(RDQ_DEPTH+1)-1:0]     rd_outstanding,
  output logic                               rd_orphan
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW = DW / 8;
  localparam int QW = $clog2(RDQ_DEPTH);
  localparam int CW = $clog2(RDQ_DEPTH + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [GW-1:0]   r_gnt;
  logic [GW-1:0]   w_gnt_next;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   w_rr_next;

  logic [AW-1:0]   w_addr  [NCH];
  logic [DW-1:0]   w_wdata [NCH];
  logic [BW-1:0]   w_wbe   [NCH];
  logic [NCH-1:0]  w_req;
  logic [NCH-1:0]  w_elig;
  logic [NCH-1:0]  w_gnt_oh;

  logic [GW-1:0]   r_tag_mem [RDQ_DEPTH];
  logic [QW-1:0]   r_wr_ptr;
  logic [QW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_orphan;
  logic [GW-1:0]   w_head;

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_rd_block;
  logic            w_granted;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign w_addr[gi]  = ch_addr[gi*AW +: AW];
    assign w_wdata[gi] = ch_wdata[gi*DW +: DW];
    assign w_wbe[gi]   = ch_wbe[gi*BW +: BW];
    assign w_req[gi]   = ch_re[gi] | ch_we[gi];
    assign w_elig[gi]  = ch_we[gi] | (ch_re[gi] & ~w_rd_block);
  end

  assign w_granted = (r_state == S_GRANT);
  assign w_gnt_oh  = NCH'(1) << r_gnt;
  assign w_accept  = w_granted & ps_cmdready & w_req[r_gnt];
  assign w_push    = w_accept & ~ch_we[r_gnt];
  assign w_pop     = ps_rdready & (r_count != '0);

  // A read accepted this edge already occupies a slot when the next grant is chosen.
  assign w_rd_block = (r_count == CW'(RDQ_DEPTH)) |
                      (w_push & (r_count == CW'(RDQ_DEPTH - 1)));

  function automatic logic [GW:0] rr_pick(input logic [NCH-1:0] mask,
                                          input logic [GW-1:0]  base);
    logic [GW:0] res;
    int          idx;
    res = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(base) + k) % NCH;
      if (mask[idx]) res = {1'b1, idx[GW-1:0]};
    end
    return res;
  endfunction

  always_ff @(posedge clk100m or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_next;
      r_gnt    <= w_gnt_next;
      r_rr_ptr <= w_rr_next;
    end
  end

  always_comb begin
    logic [GW:0]    pick;
    logic [NCH-1:0] mask;
    logic [GW-1:0]  base;
    logic           scan;
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_rr_next    = r_rr_ptr;
    mask         = '0;
    base         = r_rr_ptr;
    scan         = 1'b0;
    pick         = '0;
    case (r_state)
      S_IDLE: begin
        mask = w_elig;
        scan = 1'b1;
      end
      S_GRANT: begin
        if (!w_req[r_gnt]) begin
          w_state_next = S_IDLE;
        end else if (ps_cmdready) begin
          w_rr_next = (r_gnt == GW'(NCH - 1)) ? '0 : r_gnt + GW'(1);
          base      = w_rr_next;
          mask      = w_elig & ~w_gnt_oh;
          scan      = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (scan) begin
      pick = rr_pick(mask, base);
      if (pick[GW]) begin
        w_state_next = S_GRANT;
        w_gnt_next   = pick[GW-1:0];
      end else begin
        w_state_next = S_IDLE;
      end
    end
  end

  always_comb begin
    ps_addr     = '0;
    ps_wdata    = '0;
    ps_wbe      = '0;
    ps_re       = 1'b0;
    ps_we       = 1'b0;
    ps_refresh  = 1'b1;
    ch_cmdready = '0;
    if (w_granted) begin
      ps_addr     = w_addr[r_gnt];
      ps_wdata    = w_wdata[r_gnt];
      ps_wbe      = w_wbe[r_gnt];
      ps_we       = ch_we[r_gnt];
      ps_re       = ch_re[r_gnt] & ~ch_we[r_gnt];
      ps_refresh  = 1'b0;
      ch_cmdready = ps_cmdready ? w_gnt_oh : '0;
    end
  end

  always_ff @(posedge clk100m) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= r_gnt;
  end

  assign w_head = r_tag_mem[r_rd_ptr];

  always_ff @(posedge clk100m or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_orphan <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + QW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + QW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (ps_rdready && (r_count == '0)) r_orphan <= 1'b1;
    end
  end

  assign ch_rdata       = ps_rdata;
  assign ch_rdready     = w_pop ? (NCH'(1) << w_head) : '0;
  assign rd_outstanding = r_count;
  assign rd_orphan      = r_orphan;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a small controller model and a read-return scoreboard.
module tb_psram_arbiter;
  localparam int NCH = 2;
  localparam int AW  = 25;
  localparam int DW  = 32;
  localparam int RDQ = 4;
  localparam int CW  = $clog2(RDQ + 1);

  logic                  clk100m = 1'b0;
  logic                  rst = 1'b1;
  logic [NCH*AW-1:0]     ch_addr = '0;
  logic [NCH-1:0]        ch_re = '0;
  logic [NCH-1:0]        ch_we = '0;
  logic [NCH*DW-1:0]     ch_wdata = '0;
  logic [NCH*DW/8-1:0]   ch_wbe = '0;
  logic [NCH-1:0]        ch_cmdready;
  logic [DW-1:0]         ch_rdata;
  logic [NCH-1:0]        ch_rdready;
  logic [AW-1:0]         ps_addr;
  logic                  ps_re, ps_we, ps_refresh;
  logic [DW-1:0]         ps_wdata;
  logic [DW/8-1:0]       ps_wbe;
  logic                  ps_cmdready = 1'b1;
  logic [DW-1:0]         ps_rdata = '0;
  logic                  ps_rdready = 1'b0;
  logic [CW-1:0]         rd_outstanding;
  logic                  rd_orphan;

  int n_pass = 0;
  int n_total = 0;

  typedef struct { int ch; logic [31:0] data; } exp_t;
  exp_t        sb_q[$];
  logic [31:0] ctl_q[$];
  logic [31:0] mem [logic [AW-1:0]];

  psram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RDQ_DEPTH(RDQ)) dut (
    .clk100m(clk100m), .rst(rst),
    .ch_addr(ch_addr), .ch_re(ch_re), .ch_we(ch_we),
    .ch_wdata(ch_wdata), .ch_wbe(ch_wbe),
    .ch_cmdready(ch_cmdready), .ch_rdata(ch_rdata), .ch_rdready(ch_rdready),
    .ps_addr(ps_addr), .ps_re(ps_re), .ps_we(ps_we),
    .ps_wdata(ps_wdata), .ps_wbe(ps_wbe), .ps_refresh(ps_refresh),
    .ps_cmdready(ps_cmdready), .ps_rdata(ps_rdata), .ps_rdready(ps_rdready),
    .rd_outstanding(rd_outstanding), .rd_orphan(rd_orphan)
  );

  always #5 clk100m = ~clk100m;

  function automatic logic [31:0] dflt(input logic [AW-1:0] a);
    return {7'h2C, a};
  endfunction

  // Controller model: stores writes, queues read data in acceptance order.
  always @(posedge clk100m or posedge rst) begin
    if (rst) begin
      ctl_q.delete();
    end else if (ps_cmdready) begin
      if (ps_we) begin
        logic [31:0] d;
        d = mem.exists(ps_addr) ? mem[ps_addr] : dflt(ps_addr);
        for (int b = 0; b < 4; b++) if (ps_wbe[b]) d[b*8 +: 8] = ps_wdata[b*8 +: 8];
        mem[ps_addr] = d;
      end
      if (ps_re) ctl_q.push_back(mem.exists(ps_addr) ? mem[ps_addr] : dflt(ps_addr));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_ch(input int c, input logic re, input logic we, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    ch_re[c] = re;
    ch_we[c] = we;
    ch_addr[c*AW +: AW] = a;
    ch_wdata[c*DW +: DW] = d;
    ch_wbe[c*4 +: 4] = be;
  endtask

  task automatic tick();
    @(negedge clk100m);
  endtask

  // Waits (bounded) for ch_cmdready[c], then lets the accepting edge pass.
  task automatic wait_accept(input int c, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      #1;
      if (ch_cmdready[c]) got = 1'b1;
    end
    chk(tag, {63'd0, got}, 64'd1);
    tick();
  endtask

  task automatic issue_read(input int c, input logic [AW-1:0] a, input logic [31:0] d,
                            input int exp_out, input string tag);
    exp_t e;
    set_ch(c, 1'b1, 1'b0, a, 32'd0, 4'd0);
    e.ch = c;
    e.data = d;
    sb_q.push_back(e);
    wait_accept(c, tag);
    ch_re[c] = 1'b0;
    #1;
    chk({tag, "_outst"}, 64'(rd_outstanding), 64'(exp_out));
    $display("read ch%0d addr %h issued, outstanding %0d", c, a, rd_outstanding);
  endtask

  // One controller return; compared against the scoreboard head.
  task automatic ret(input string tag);
    exp_t e;
    e.ch = 0;
    e.data = '0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    chk({tag, "_ctlq"}, {63'd0, ctl_q.size() > 0}, 64'd1);
    ps_rdata = (ctl_q.size() > 0) ? ctl_q.pop_front() : 32'd0;
    ps_rdready = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(ch_rdready), 64'(1 << e.ch));
    chk({tag, "_data"}, 64'(ch_rdata), 64'(e.data));
    $display("return ch_rdready %b data %h (expect ch%0d %h)", ch_rdready, ch_rdata, e.ch, e.data);
    tick();
    ps_rdready = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    tick();
    tick();
    #1;
    chk("rst_cmdready", 64'(ch_cmdready), 64'd0);
    chk("rst_rdready", 64'(ch_rdready), 64'd0);
    chk("rst_re_we", {62'd0, ps_re, ps_we}, 64'd0);
    chk("rst_addr", 64'(ps_addr), 64'd0);
    chk("rst_wdata", {28'd0, ps_wbe, ps_wdata}, 64'd0);
    chk("rst_refresh", 64'(ps_refresh), 64'd1);
    chk("rst_outst", 64'(rd_outstanding), 64'd0);
    chk("rst_orphan", 64'(rd_orphan), 64'd0);
    rst = 1'b0;

    // Single channel write then read back
    tick();
    set_ch(0, 1'b0, 1'b1, 25'h123457, 32'hA90D20D2, 4'hF);
    #1;
    chk("t1_we_lat0", 64'(ps_we), 64'd0);
    tick();
    #1;
    chk("t1_we_lat1", {62'd0, ps_we, ps_re}, 64'd2);
    chk("t1_addr", 64'(ps_addr), 64'h123457);
    chk("t1_wdata", {28'd0, ps_wbe, ps_wdata}, {28'd0, 4'hF, 32'hA90D20D2});
    chk("t1_cmdready", 64'(ch_cmdready), 64'd1);
    $display("write ch0 addr %h data %h cmdready %b", ps_addr, ps_wdata, ch_cmdready);
    tick();
    ch_we[0] = 1'b0;
    #1;
    chk("t1_idle_refresh", 64'(ps_refresh), 64'd1);
    issue_read(0, 25'h123457, 32'hA90D20D2, 1, "t1_rd");
    ret("t1_ret");
    chk("t1_outst0", 64'(rd_outstanding), 64'd0);

    // Contention: both channels writing, ps_cmdready high
    set_ch(0, 1'b0, 1'b1, 25'h000100, 32'h11111111, 4'hF);
    set_ch(1, 1'b0, 1'b1, 25'h000200, 32'h22222222, 4'hF);
    tick();
    g = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t2_refresh", 64'(ps_refresh), 64'd0);
      chk("t2_grant", 64'(ch_cmdready), 64'(1 << g));
      $display("contention cycle %0d grant %b", i, ch_cmdready);
      g = 1 - g;
      tick();
    end
    ch_we = '0;
    tick();

    // Read interleave ch0, ch1, ch0
    issue_read(0, 25'h0000A0, dflt(25'h0000A0), 1, "t3_rdA");
    issue_read(1, 25'h0000B0, dflt(25'h0000B0), 2, "t3_rdB");
    issue_read(0, 25'h0000C0, dflt(25'h0000C0), 3, "t3_rdC");
    ret("t3_retA");
    ret("t3_retB");
    ret("t3_retC");
    chk("t3_outst0", 64'(rd_outstanding), 64'd0);

    // FIFO full blocks a 5th read but not a write
    for (int i = 0; i < 4; i++)
      issue_read(0, 25'h000D00 + 25'(i), dflt(25'h000D00 + 25'(i)), i + 1, "t4_fill");
    begin
      exp_t e;
      set_ch(0, 1'b1, 1'b0, 25'h000D04, 32'd0, 4'd0);
      e.ch = 0;
      e.data = dflt(25'h000D04);
      sb_q.push_back(e);
    end
    set_ch(1, 1'b0, 1'b1, 25'h000E00, 32'h33333333, 4'h3);
    wait_accept(1, "t4_wr_acc");
    ch_we[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t4_rd_blocked", {62'd0, ps_re, ch_cmdready[0]}, 64'd0);
      tick();
    end
    ret("t4_ret0");
    chk("t4_same_edge_block", 64'(ps_re), 64'd0);
    chk("t4_outst3", 64'(rd_outstanding), 64'd3);
    tick();
    #1;
    chk("t4_rd5_grant", {62'd0, ps_re, ch_cmdready[0]}, 64'd3);
    chk("t4_rd5_addr", 64'(ps_addr), 64'h000D04);
    tick();
    ch_re[0] = 1'b0;
    #1;
    chk("t4_outst4", 64'(rd_outstanding), 64'd4);
    for (int i = 0; i < 4; i++) ret("t4_drain");
    chk("t4_outst0", 64'(rd_outstanding), 64'd0);

    // Orphan return
    chk("t5_orphan_pre", 64'(rd_orphan), 64'd0);
    ps_rdata = 32'hDEADBEEF;
    ps_rdready = 1'b1;
    #1;
    chk("t5_rdready", 64'(ch_rdready), 64'd0);
    tick();
    ps_rdready = 1'b0;
    #1;
    chk("t5_orphan", 64'(rd_orphan), 64'd1);
    chk("t5_outst", 64'(rd_outstanding), 64'd0);
    $display("orphan pulse: rd_orphan %b", rd_orphan);
    tick();
    tick();
    #1;
    chk("t5_orphan_sticky", 64'(rd_orphan), 64'd1);

    // Reset while GRANT(1) with two reads outstanding
    issue_read(0, 25'h000F00, dflt(25'h000F00), 1, "t6_rd");
    issue_read(0, 25'h000F01, dflt(25'h000F01), 2, "t6_rd");
    ps_cmdready = 1'b0;
    set_ch(1, 1'b0, 1'b1, 25'h000F80, 32'h44444444, 4'hF);
    tick();
    #1;
    chk("t6_grant1", {62'd0, ps_we, ch_cmdready[1]}, 64'd2);
    chk("t6_addr", 64'(ps_addr), 64'h000F80);
    chk("t6_orphan_held", 64'(rd_orphan), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_we", {62'd0, ps_we, ps_re}, 64'd0);
    chk("t6_rst_addr", 64'(ps_addr), 64'd0);
    chk("t6_rst_wdata", {28'd0, ps_wbe, ps_wdata}, 64'd0);
    chk("t6_rst_refresh", 64'(ps_refresh), 64'd1);
    chk("t6_rst_outst", 64'(rd_outstanding), 64'd0);
    chk("t6_rst_orphan", 64'(rd_orphan), 64'd0);
    chk("t6_rst_cmdready", 64'(ch_cmdready), 64'd0);
    $display("async reset: refresh %b outstanding %0d", ps_refresh, rd_outstanding);
    sb_q.delete();
    ch_we = '0;
    ps_cmdready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ps_rdready = 1'b1;
    #1;
    chk("t6_late_rdready", 64'(ch_rdready), 64'd0);
    tick();
    ps_rdready = 1'b0;
    #1;
    chk("t6_late_orphan", 64'(rd_orphan), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
